// File: rtl/game_ctrl_pkg.sv
// Shared state encodings and helpers for the breakout game sequencer.
package game_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4,
    ST_WIN   = 3'd5
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_ctrl_edge_det.sv
// Rising-edge detector; history resets to 1 so a level held through reset gives no edge.
// Combinational output, one register of history.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b1;
    else     prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/game_ctrl.sv
// Breakout game sequencer: lives/score, frame timer and paddle/ball reset/enable.
// All outputs registered, one cycle after the triggering input.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 90,
  parameter int SCORE_W      = 10,
  parameter int PTS_PER_HIT  = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ani_stb,
  input  logic               i_btn_start,
  input  logic               i_miss,
  input  logic               i_hit,
  input  logic               i_clear,
  output logic [2:0]         o_state,
  output logic               o_obj_rst,
  output logic               o_animate,
  output logic [2:0]         o_lives,
  output logic [SCORE_W-1:0] o_score
);

  localparam int TW = $clog2(max_int(SERVE_FRAMES, MISS_FRAMES) + 1);
  localparam logic [TW-1:0]      T_SERVE    = TW'(SERVE_FRAMES);
  localparam logic [TW-1:0]      T_MISS     = TW'(MISS_FRAMES);
  localparam logic [TW-1:0]      T_ONE      = TW'(1);
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
  localparam logic [SCORE_W:0]   PTS_EXT    = (SCORE_W+1)'(PTS_PER_HIT);

  state_t             state;
  logic [TW-1:0]      timer;
  logic [2:0]         lives;
  logic [SCORE_W-1:0] score;
  logic               obj_rst;
  logic               animate;
  logic               start_edge;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_inc;

  edge_det u_start (
    .clk   (i_clk),
    .rst   (i_rst),
    .level (i_btn_start),
    .rise  (start_edge)
  );

  // Extra carry bit catches overflow so the score pins at all-ones.
  assign score_sum = {1'b0, score} + PTS_EXT;
  assign score_inc = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      obj_rst <= 1'b1;
      animate <= 1'b0;
      lives   <= LIVES_INIT;
      score   <= '0;
      timer   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          obj_rst <= 1'b1;
          animate <= 1'b0;
          if (start_edge) begin
            lives <= LIVES_INIT;
            score <= '0;
            timer <= T_SERVE;
            state <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          obj_rst <= 1'b0;
          animate <= 1'b0;
          if (i_ani_stb) begin
            if (timer == T_ONE) begin
              state   <= ST_PLAY;
              animate <= 1'b1;
            end else begin
              timer <= timer - T_ONE;
            end
          end
        end
        ST_PLAY: begin
          obj_rst <= 1'b0;
          animate <= 1'b1;
          if (i_hit) score <= score_inc;
          // Clearing the wall wins even if the ball drops in the same cycle.
          if (i_clear) begin
            state   <= ST_WIN;
            animate <= 1'b0;
          end else if (i_miss) begin
            lives   <= lives - 3'd1;
            timer   <= T_MISS;
            state   <= ST_MISS;
            animate <= 1'b0;
          end
        end
        ST_MISS: begin
          obj_rst <= 1'b0;
          animate <= 1'b0;
          if (i_ani_stb) begin
            if (timer == T_ONE) begin
              if (lives == 3'd0) begin
                state <= ST_OVER;
              end else begin
                state   <= ST_SERVE;
                timer   <= T_SERVE;
                obj_rst <= 1'b1;
              end
            end else begin
              timer <= timer - T_ONE;
            end
          end
        end
        ST_OVER, ST_WIN: begin
          obj_rst <= 1'b0;
          animate <= 1'b0;
          if (start_edge) begin
            lives   <= LIVES_INIT;
            score   <= '0;
            timer   <= T_SERVE;
            obj_rst <= 1'b1;
            state   <= ST_SERVE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          obj_rst <= 1'b1;
          animate <= 1'b0;
        end
      endcase
    end
  end

  assign o_state   = state;
  assign o_obj_rst = obj_rst;
  assign o_animate = animate;
  assign o_lives   = lives;
  assign o_score   = score;

endmodule

// File: tb/tb_game_ctrl.sv
// Vector-table bench for game_ctrl with a small expected-result queue.
module tb_game_ctrl;

  localparam int LIVES = 2, SERVE_FRAMES = 4, MISS_FRAMES = 3, SCORE_W = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic ani_stb = 1'b0, btn_start = 1'b0, miss = 1'b0, hit = 1'b0, clear = 1'b0;
  logic [2:0] state;
  logic obj_rst, animate;
  logic [2:0] lives;
  logic [SCORE_W-1:0] score;

  int n_vec = 0;
  int n_err = 0;

  game_ctrl #(
    .LIVES(LIVES), .SERVE_FRAMES(SERVE_FRAMES), .MISS_FRAMES(MISS_FRAMES),
    .SCORE_W(SCORE_W), .PTS_PER_HIT(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_ani_stb(ani_stb), .i_btn_start(btn_start),
    .i_miss(miss), .i_hit(hit), .i_clear(clear),
    .o_state(state), .o_obj_rst(obj_rst), .o_animate(animate),
    .o_lives(lives), .o_score(score)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic btn, stb, miss, hit, clear;
    logic [2:0] st;
    logic orst, ani;
    logic [2:0] lives;
    logic [3:0] score;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic b, input logic s, input logic m, input logic h,
                              input logic c, input int st, input logic orst, input logic ani,
                              input int lv, input int sc);
    vec_t v;
    v.btn = b; v.stb = s; v.miss = m; v.hit = h; v.clear = c;
    v.st = 3'(st); v.orst = orst; v.ani = ani; v.lives = 3'(lv); v.score = 4'(sc);
    return v;
  endfunction

  task automatic compare(input vec_t e, input string name);
    n_vec++;
    if (state !== e.st || obj_rst !== e.orst || animate !== e.ani ||
        lives !== e.lives || score !== e.score) begin
      n_err++;
      $display("FAIL %s: got st=%0d obj_rst=%0b ani=%0b lives=%0d score=%0d, want st=%0d obj_rst=%0b ani=%0b lives=%0d score=%0d",
               name, state, obj_rst, animate, lives, score,
               e.st, e.orst, e.ani, e.lives, e.score);
    end
  endtask

  task automatic step(input vec_t v, input string name);
    vec_t e;
    btn_start = v.btn; ani_stb = v.stb; miss = v.miss; hit = v.hit; clear = v.clear;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    compare(e, name);
  endtask

  initial begin
    // 1. start, serve timing
    tbl.push_back(mk(0,0,0,0,0, 0,1,0,2,0));
    tbl.push_back(mk(1,0,0,0,0, 1,1,0,2,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,2,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,0,0,0, 1,0,0,2,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,2,0));
    tbl.push_back(mk(0,1,0,0,0, 2,0,1,2,0));
    // 2. score saturation
    for (int i = 1; i <= 17; i++) tbl.push_back(mk(0,0,0,1,0, 2,0,1,2, (i > 15) ? 15 : i));
    // 3. two misses down to OVER
    tbl.push_back(mk(0,0,1,0,0, 3,0,0,1,15));
    tbl.push_back(mk(0,0,0,1,0, 3,0,0,1,15));
    tbl.push_back(mk(0,1,0,0,0, 3,0,0,1,15));
    tbl.push_back(mk(0,1,0,0,0, 3,0,0,1,15));
    tbl.push_back(mk(0,1,0,0,0, 1,1,0,1,15));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,0,0,0, 1,0,0,1,15));
    tbl.push_back(mk(0,1,0,0,0, 2,0,1,1,15));
    tbl.push_back(mk(1,0,1,0,0, 3,0,0,0,15));
    tbl.push_back(mk(0,1,0,0,0, 3,0,0,0,15));
    tbl.push_back(mk(0,1,0,0,0, 3,0,0,0,15));
    tbl.push_back(mk(0,1,0,0,0, 4,0,0,0,15));
    tbl.push_back(mk(0,0,1,1,0, 4,0,0,0,15));
    // restart from OVER, hit+miss together, then clear+miss -> WIN
    tbl.push_back(mk(1,0,0,0,0, 1,1,0,2,0));
    tbl.push_back(mk(1,0,0,0,0, 1,0,0,2,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,0,0,0, 1,0,0,2,0));
    tbl.push_back(mk(0,1,0,0,0, 2,0,1,2,0));
    tbl.push_back(mk(0,0,0,1,0, 2,0,1,2,1));
    tbl.push_back(mk(0,0,1,1,0, 3,0,0,1,2));
    tbl.push_back(mk(0,1,0,0,0, 3,0,0,1,2));
    tbl.push_back(mk(0,1,0,0,0, 3,0,0,1,2));
    tbl.push_back(mk(0,1,0,0,0, 1,1,0,1,2));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,0,0,0, 1,0,0,1,2));
    tbl.push_back(mk(0,1,0,0,0, 2,0,1,1,2));
    tbl.push_back(mk(0,0,1,0,1, 5,0,0,1,2));
    tbl.push_back(mk(0,0,0,1,0, 5,0,0,1,2));
    tbl.push_back(mk(1,0,0,0,0, 1,1,0,2,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,2,0));

    #12;
    compare(mk(0,0,0,0,0, 0,1,0,2,0), "reset");
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("tbl[%0d]", i));

    // 5. button held through reset release
    btn_start = 1'b1;
    rst = 1'b1;
    #1;
    compare(mk(0,0,0,0,0, 0,1,0,2,0), "rst_btn_held");
    @(negedge clk) rst = 1'b0;
    step(mk(1,0,0,0,0, 0,1,0,2,0), "held_a");
    step(mk(1,0,0,0,0, 0,1,0,2,0), "held_b");
    step(mk(0,0,0,0,0, 0,1,0,2,0), "released");
    step(mk(1,0,0,0,0, 1,1,0,2,0), "press");

    // 6. async reset in MISS with timer at 2
    for (int i = 0; i < 3; i++) step(mk(0,1,0,0,0, 1,0,0,2,0), "serve6");
    step(mk(0,1,0,0,0, 2,0,1,2,0), "play6");
    step(mk(0,0,0,1,0, 2,0,1,2,1), "hit6");
    step(mk(0,0,1,0,0, 3,0,0,1,1), "miss6");
    step(mk(0,1,0,0,0, 3,0,0,1,1), "miss6_t2");
    ani_stb = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    compare(mk(0,0,0,0,0, 0,1,0,2,0), "async_rst");
    @(negedge clk) rst = 1'b0;
    step(mk(0,0,0,0,0, 0,1,0,2,0), "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
